// File: rtl/axi_hs_throttle_pkg.sv
// Shared types and constants for the valid/ready throttle: mode encoding,
// periodic phase states, LFSR polynomial and per-channel seed derivation.
package axi_hs_throttle_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_RANDOM   = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_BLOCK    = 2'd3
  } mode_e;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_e;

  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // An all-zero Galois LFSR never leaves zero, so that seed is remapped.
  function automatic logic [15:0] ch_seed(input logic [15:0] seed, input int unsigned ch);
    logic [15:0] s;
    s = seed ^ 16'(ch + 1);
    return (s == '0) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/axi_hs_throttle_if.sv
// Per-channel valid/ready bundle between upstream master, throttle and
// downstream slave. The throttle itself connects through the slave modport.
interface axi_hs_throttle_if #(
  parameter int unsigned N_CH = 5
);
  logic [N_CH-1:0] up_valid;
  logic [N_CH-1:0] up_ready;
  logic [N_CH-1:0] dn_valid;
  logic [N_CH-1:0] dn_ready;

  modport master (
    output up_valid,
    output dn_ready,
    input  up_ready,
    input  dn_valid
  );

  modport slave (
    input  up_valid,
    input  dn_ready,
    output up_ready,
    output dn_valid
  );
endinterface

// File: rtl/axi_hs_throttle_ch.sv
// One throttled valid/ready channel: LFSR, periodic phase counter, registered
// gate, AXI-stability hold and saturating stall counter.
module axi_hs_throttle_ch
  import axi_hs_throttle_pkg::*;
#(
  parameter int unsigned PROB_W  = 10,
  parameter int unsigned PER_W   = 8,
  parameter int unsigned CNT_W   = 32,
  parameter logic [15:0] CH_SEED = 16'h0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cfg_mode,
  input  logic [PROB_W:0]    cfg_thresh,
  input  logic [PER_W-1:0]   cfg_on_len,
  input  logic [PER_W-1:0]   cfg_off_len,
  input  logic               up_valid,
  output logic               up_ready,
  output logic               dn_valid,
  input  logic               dn_ready,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   stall_cnt
);

  mode_e            mode;
  phase_e           phase_q, phase_d;
  logic [PER_W-1:0] pcnt_q, pcnt_d;
  logic [PER_W:0]   pcnt_inc;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             gate_q, gate_d;
  logic             hold_q, hold_d;
  logic             open;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign mode      = mode_e'(cfg_mode);
  assign open      = gate_q | hold_q;
  assign dn_valid  = up_valid & open;
  assign up_ready  = dn_ready & open;
  assign stall_cnt = cnt_q;
  assign pcnt_inc  = {1'b0, pcnt_q} + (PER_W+1)'(1);

  always_comb begin
    gate_d  = 1'b0;
    phase_d = PH_ON;
    pcnt_d  = '0;
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : '0);
    case (mode)
      MODE_PASS:   gate_d = 1'b1;
      MODE_RANDOM: gate_d = ({1'b0, lfsr_q[PROB_W-1:0]} < cfg_thresh);
      MODE_PERIODIC: begin
        // Zero on_len forces closed; zero off_len forces open regardless of phase.
        gate_d  = (cfg_on_len != '0) && ((cfg_off_len == '0) || (phase_q == PH_ON));
        phase_d = phase_q;
        pcnt_d  = pcnt_inc[PER_W-1:0];
        if ((phase_q == PH_ON) && (pcnt_inc >= {1'b0, cfg_on_len})) begin
          phase_d = PH_OFF;
          pcnt_d  = '0;
        end else if ((phase_q == PH_OFF) && (pcnt_inc >= {1'b0, cfg_off_len})) begin
          phase_d = PH_ON;
          pcnt_d  = '0;
        end
      end
      MODE_BLOCK:  gate_d = 1'b0;
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    if (dn_valid) hold_d = ~dn_ready;
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (up_valid && !open && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= CH_SEED;
      gate_q  <= 1'b0;
      hold_q  <= 1'b0;
      phase_q <= PH_ON;
      pcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      gate_q  <= gate_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_hs_throttle.sv
// Multi-channel valid/ready throttle: N_CH independent channels gated by
// pass/random/periodic/block policies; payload never passes through here.
module axi_hs_throttle
  import axi_hs_throttle_pkg::*;
#(
  parameter int unsigned N_CH   = 5,
  parameter int unsigned PROB_W = 10,
  parameter int unsigned PER_W  = 8,
  parameter int unsigned CNT_W  = 32,
  parameter logic [15:0] SEED   = DEFAULT_SEED
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH-1:0][1:0]         cfg_mode,
  input  logic [N_CH-1:0][PROB_W:0]    cfg_thresh,
  input  logic [N_CH-1:0][PER_W-1:0]   cfg_on_len,
  input  logic [N_CH-1:0][PER_W-1:0]   cfg_off_len,
  axi_hs_throttle_if.slave             hs,
  input  logic                         cnt_clr,
  output logic [N_CH-1:0][CNT_W-1:0]   stall_cnt
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    axi_hs_throttle_ch #(
      .PROB_W  (PROB_W),
      .PER_W   (PER_W),
      .CNT_W   (CNT_W),
      .CH_SEED (ch_seed(SEED, g))
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .cfg_mode    (cfg_mode[g]),
      .cfg_thresh  (cfg_thresh[g]),
      .cfg_on_len  (cfg_on_len[g]),
      .cfg_off_len (cfg_off_len[g]),
      .up_valid    (hs.up_valid[g]),
      .up_ready    (hs.up_ready[g]),
      .dn_valid    (hs.dn_valid[g]),
      .dn_ready    (hs.dn_ready[g]),
      .cnt_clr     (cnt_clr),
      .stall_cnt   (stall_cnt[g])
    );
  end

endmodule
